// File: rtl/clz_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clz_seq_pkg
// Description : Shared mode codes, FSM state encoding and width helper for
//               the sequential leading/trailing zero/one counter.
// Revision    : 1.0 - initial release
// ============================================================================
package clz_seq_pkg;

    localparam logic [1:0] MODE_CLZ = 2'b00;
    localparam logic [1:0] MODE_CLO = 2'b01;
    localparam logic [1:0] MODE_CTZ = 2'b10;
    localparam logic [1:0] MODE_CTO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bits needed to hold a count in the range 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clz_seq_unit_chunk_lzc.sv
`default_nettype none
// ============================================================================
// Module      : chunk_lzc
// Description : Combinational leading-zero count of one CHUNK-bit slice,
//               priority encoded from the MSB; reports CHUNK when all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_lzc
    import clz_seq_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]           bits,
    output logic [cnt_w(CHUNK)-1:0]    lz,
    output logic                       all_zero
);

    localparam int LZW = cnt_w(CHUNK);

    // Walk upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        lz = LZW'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (bits[i]) begin
                lz = LZW'(CHUNK - 1 - i);
            end
        end
    end

    assign all_zero = ~|bits;

endmodule
`default_nettype wire

// File: rtl/clz_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : clz_seq_unit
// Description : Multi-cycle CLZ/CLO/CTZ/CTO counter scanning CHUNK bits per
//               clock with early termination and a start/ready/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module clz_seq_unit
    import clz_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_w(WIDTH);
    localparam int LZW    = cnt_w(CHUNK);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] c_idx_last = IW'(NCHUNK - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_count;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_capt;
    logic [LZW-1:0]   w_lz;
    logic             w_all_zero;

    // Every mode is reduced to "count leading zeros" at capture time.
    assign w_inv = mode[0] ? ~data_in : data_in;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign w_capt[gi] = mode[1] ? w_inv[WIDTH-1-gi] : w_inv[gi];
        end
    endgenerate

    chunk_lzc #(
        .CHUNK (CHUNK)
    ) u_chunk_lzc (
        .bits     (r_sh[WIDTH-1 -: CHUNK]),
        .lz       (w_lz),
        .all_zero (w_all_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sh     <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sh    <= w_capt;
                        r_count <= '0;
                        r_idx   <= '0;
                        r_state <= ST_SCAN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_all_zero && (r_idx != c_idx_last)) begin
                        r_count <= r_count + CW'(CHUNK);
                        r_sh    <= r_sh << CHUNK;
                        r_idx   <= r_idx + IW'(1);
                    end else begin
                        // An all-zero last chunk reports lz=CHUNK, giving WIDTH.
                        r_result <= WIDTH'(r_count + CW'(w_lz));
                        r_state  <= ST_DONE;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_clz_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_clz_seq_unit
// Description : Self-checking bench for clz_seq_unit with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clz_seq_unit;
    import clz_seq_pkg::*;

    localparam int W  = 32;
    localparam int C  = 8;
    localparam int NC = W / C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] data_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    clz_seq_unit #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .data_in (data_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Count of leading/trailing bits equal to mode[0], straight from the definition.
    function automatic int ref_count(input logic [1:0] m, input logic [W-1:0] d);
        int n = 0;
        if (!m[1]) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (d[i] !== m[0]) break;
                n++;
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                if (d[i] !== m[0]) break;
                n++;
            end
        end
        return n;
    endfunction

    function automatic int ref_lat(input int n);
        return ((n == W) ? NC - 1 : n / C) + 2;
    endfunction

    // Model: edges remaining until done, and the pending answer.
    int           m_left  = 0;
    logic         m_done  = 1'b0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_pend   = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_valid  <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_result <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= W'(ref_count(mode, data_in));
                m_left <= ref_lat(ref_count(mode, data_in)) - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ready",  ready,  (m_left == 0));
            check("busy",   busy,   (m_left > 0));
            check("done",   done,   m_done);
            check("result", result, m_result);
        end
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    // Issue one op (from a ready cycle), optionally poke start during SCAN.
    task automatic run_op(input logic [1:0] m, input logic [W-1:0] d,
                          input int exp_res, input int exp_lat, input int poke);
        int lat;
        int guard = 0;
        while (!ready && guard < 100) begin
            idle_cycle();
            guard++;
        end
        start = 1'b1; mode = m; data_in = d;
        idle_cycle();
        start = 1'b0; mode = 'x; data_in = 'x;
        lat = 1;
        while (!done && lat < 100) begin
            if (poke != 0 && lat == poke) begin
                start = 1'b1; mode = MODE_CLZ; data_in = '1;
            end
            idle_cycle();
            start = 1'b0; mode = 'x; data_in = 'x;
            lat++;
        end
        check("op_latency", lat, exp_lat);
        check("op_result", result, exp_res);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [1:0]   m;
        int           s;
        int           n;
        rst_n = 1'b0; start = 1'b0; mode = 'x; data_in = 'x;
        idle_cycle();
        idle_cycle();
        check("rst_ready",  ready,  1);
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_result", result, 0);
        rst_n = 1'b1;
        idle_cycle();

        run_op(MODE_CLZ, 32'h8000_0000, 0, 2, 0);   idle_cycle();
        run_op(MODE_CLZ, 32'h0000_0001, 31, 5, 0);  idle_cycle();
        run_op(MODE_CLZ, 32'h0000_0000, 32, 5, 0);  idle_cycle();
        run_op(MODE_CLO, 32'hFFF0_0000, 12, 3, 0);  idle_cycle();
        run_op(MODE_CTZ, 32'h0000_0100, 8, 3, 0);   idle_cycle();
        run_op(MODE_CTO, 32'hFFFF_FFFF, 32, 5, 0);  idle_cycle();
        run_op(MODE_CTO, 32'h0000_007F, 7, 2, 0);   idle_cycle();
        run_op(MODE_CLO, 32'h0000_0000, 0, 2, 0);   idle_cycle();

        // Back-to-back: second start issued in the DONE cycle of the first.
        run_op(MODE_CLZ, 32'h8000_0000, 0, 2, 0);
        run_op(MODE_CLZ, 32'h00FF_0000, 8, 3, 0);
        idle_cycle();

        // start during SCAN must not disturb the running operation.
        run_op(MODE_CLZ, 32'h0000_0000, 32, 5, 2);
        idle_cycle();

        // Reset during the second SCAN cycle aborts the operation.
        start = 1'b1; mode = MODE_CLZ; data_in = '0;
        idle_cycle();
        start = 1'b0; mode = 'x; data_in = 'x;
        idle_cycle();
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        check("abort_ready",  ready,  1);
        check("abort_busy",   busy,   0);
        check("abort_result", result, 0);
        for (int k = 0; k < 5; k++) begin
            check("abort_no_done", done, 0);
            idle_cycle();
        end
        run_op(MODE_CLZ, 32'h4000_0000, 1, 2, 0);
        idle_cycle();

        // Random operands shaped to spread counts over the whole range.
        for (int k = 0; k < 48; k++) begin
            m = 2'($urandom_range(0, 3));
            s = $urandom_range(0, W);
            d = W'($urandom) | W'(1 << (W - 1));
            d = (s >= W) ? '0 : (d >> s);
            if (m[0]) d = ~d;
            if (m[1]) d = {<<{d}};
            n = ref_count(m, d);
            run_op(m, d, n, ref_lat(n), 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
